// File: rtl/mem_stage_ctrl_if.sv
// Memory-side bus of the MEM pipeline stage: the controller drives the request,
// the memory returns read data and a completion strobe.
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues one memory access per load/store and freezes the pipeline until done.
// Optional macro MEM_TIMEOUT_EN adds a 255-cycle WAIT timeout with a sticky mem_err flag.
module mem_stage_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic             WB_EN_IN,
  input  logic             MEM_R_EN_IN,
  input  logic             MEM_W_EN_IN,
  input  logic [31:0]      ALUResIn,
  input  logic [31:0]      stValIn,
  input  logic [4:0]       destIn,
  mem_stage_ctrl_if.master mem,
  output logic             freeze,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic [31:0]      ALURes,
  output logic [31:0]      memReadVal,
  output logic [4:0]       dest,
  output logic             mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state;
  state_t state_nxt;
  logic   access;
  logic   timeout;

  assign access   = MEM_R_EN_IN | MEM_W_EN_IN;
  assign WB_EN    = WB_EN_IN;
  assign MEM_R_EN = MEM_R_EN_IN;
  assign ALURes   = ALUResIn;
  assign dest     = destIn;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // wait_cnt holds (WAIT cycles elapsed - 1), so 254 marks the 255th WAIT cycle
  assign timeout = (state == WAIT) && !mem.mem_ready && (wait_cnt == 8'd254);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      if (state == IDLE && access) begin
        wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout) begin
        mem_err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    freeze      = 1'b0;
    mem.mem_req = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          freeze    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        freeze      = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ready || timeout) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A request is a read unless it was a pure store, so ~mem_we doubles as the read flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      mem.mem_we    <= 1'b0;
      memReadVal    <= 32'd0;
    end else begin
      if (state == IDLE && access) begin
        mem.mem_addr  <= ALUResIn;
        mem.mem_wdata <= stValIn;
        mem.mem_we    <= MEM_W_EN_IN & ~MEM_R_EN_IN;
      end
      if (state == WAIT) begin
        if (mem.mem_ready) begin
          memReadVal <= mem.mem_we ? 32'd0 : mem.mem_rdata;
        end else if (timeout) begin
          memReadVal <= 32'hDEADBEEF;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized instruction
// streams compared against an instruction-level model of freeze/request occupancy.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        WB_EN_IN;
  logic        MEM_R_EN_IN;
  logic        MEM_W_EN_IN;
  logic [31:0] ALUResIn;
  logic [31:0] stValIn;
  logic [4:0]  destIn;
  logic        freeze;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic [31:0] ALURes;
  logic [31:0] memReadVal;
  logic [4:0]  dest;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .WB_EN_IN    (WB_EN_IN),
    .MEM_R_EN_IN (MEM_R_EN_IN),
    .MEM_W_EN_IN (MEM_W_EN_IN),
    .ALUResIn    (ALUResIn),
    .stValIn     (stValIn),
    .destIn      (destIn),
    .mem         (bus),
    .freeze      (freeze),
    .WB_EN       (WB_EN),
    .MEM_R_EN    (MEM_R_EN),
    .ALURes      (ALURes),
    .memReadVal  (memReadVal),
    .dest        (dest),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    MEM_R_EN_IN = 1'b0;
    MEM_W_EN_IN = 1'b0;
    WB_EN_IN    = 1'b0;
    ALUResIn    = 32'd0;
    stValIn     = 32'd0;
    destIn      = 5'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Plays one instruction through the stage (memory answers in WAIT cycle n) and
  // records per-cycle freeze/mem_req bits plus the values seen on the bus.
  task automatic exec_instr(
    input  logic        r, w, wb,
    input  logic [31:0] addr, sv, rd,
    input  logic [4:0]  dst,
    input  int          n,
    output logic [15:0] frz, req,
    output logic [31:0] o_addr, o_wdata, o_rval,
    output logic        o_we, o_stable, o_wb, o_mr,
    output logic [31:0] o_alu,
    output logic [4:0]  o_dest
  );
    int  len;
    logic is_mem;
    is_mem = r | w;
    len = is_mem ? n + 2 : 1;
    frz = '0; req = '0; o_addr = '0; o_wdata = '0; o_rval = '0;
    o_we = 1'b0; o_stable = 1'b1; o_wb = 1'b0; o_mr = 1'b0; o_alu = '0; o_dest = '0;
    MEM_R_EN_IN = r;
    MEM_W_EN_IN = w;
    WB_EN_IN    = wb;
    ALUResIn    = addr;
    stValIn     = sv;
    destIn      = dst;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (is_mem && c <= n) begin
          bus.mem_ready = (c == n);
          bus.mem_rdata = (c == n) ? rd : $urandom;
        end else begin
          bus.mem_ready = 1'($urandom_range(0, 1));
          bus.mem_rdata = $urandom;
        end
      end
      @(negedge clk);
      frz[c] = freeze;
      req[c] = bus.mem_req;
      if (c == 0) begin
        o_wb = WB_EN; o_mr = MEM_R_EN; o_alu = ALURes; o_dest = dest;
      end
      if (c == 1) begin
        o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_we = bus.mem_we;
      end else if (is_mem && c > 1 && c <= n) begin
        if (bus.mem_addr !== o_addr || bus.mem_wdata !== o_wdata || bus.mem_we !== o_we)
          o_stable = 1'b0;
      end
      if (c == len - 1) o_rval = memReadVal;
    end
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0; WB_EN_IN = 1'b0;
    ALUResIn = 32'h1234; stValIn = 32'h5678; destIn = 5'd3;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req, bus.mem_we, freeze, mem_err} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: req/we/freeze/err=%b required 0000",
               {bus.mem_req, bus.mem_we, freeze, mem_err});
    end
    n_checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || memReadVal !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: addr=%h wdata=%h rval=%h required all 0",
               bus.mem_addr, bus.mem_wdata, memReadVal);
    end
    MEM_R_EN_IN = 1'b1;
    #1;
    n_checks++;
    if (freeze !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_decode: freeze=%b req=%b required freeze=1 req=0", freeze, bus.mem_req);
    end
    do_reset();
  endtask

  task automatic test_load();
    logic [15:0] frz, req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    exec_instr(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'hCAFEF00D, 5'd7, 2,
               frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
    n_checks++;
    if (frz !== 16'b0111) begin
      n_fail++; $display("[TB] FAIL load_freeze: got %b required %b", frz, 16'b0111);
    end
    n_checks++;
    if (req !== 16'b0110) begin
      n_fail++; $display("[TB] FAIL load_req: got %b required %b", req, 16'b0110);
    end
    n_checks++;
    if (o_addr !== 32'h100 || o_we !== 1'b0 || o_stable !== 1'b1) begin
      n_fail++; $display("[TB] FAIL load_bus: addr=%h we=%b stable=%b required 100/0/1", o_addr, o_we, o_stable);
    end
    n_checks++;
    if (o_rval !== 32'hCAFEF00D) begin
      n_fail++; $display("[TB] FAIL load_rval: got %h required cafef00d", o_rval);
    end
  endtask

  task automatic test_store();
    logic [15:0] frz, req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    exec_instr(1'b0, 1'b1, 1'b0, 32'h40, 32'h12345678, 32'hAAAA5555, 5'd0, 1,
               frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
    n_checks++;
    if (frz !== 16'b011 || req !== 16'b010) begin
      n_fail++; $display("[TB] FAIL store_occupancy: freeze=%b req=%b required 011/010", frz, req);
    end
    n_checks++;
    if (o_we !== 1'b1 || o_addr !== 32'h40 || o_wdata !== 32'h12345678) begin
      n_fail++; $display("[TB] FAIL store_bus: we=%b addr=%h wdata=%h required 1/40/12345678", o_we, o_addr, o_wdata);
    end
    n_checks++;
    if (o_rval !== 32'd0) begin
      n_fail++; $display("[TB] FAIL store_rval: got %h required 0", o_rval);
    end
    // Read and write together behave as a read
    exec_instr(1'b1, 1'b1, 1'b0, 32'h80, 32'h99, 32'h0BADF00D, 5'd1, 1,
               frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
    n_checks++;
    if (o_we !== 1'b0 || o_rval !== 32'h0BADF00D) begin
      n_fail++; $display("[TB] FAIL rw_as_read: we=%b rval=%h required 0/0badf00d", o_we, o_rval);
    end
  endtask

  task automatic test_nonmem();
    logic [15:0] frz, req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    exec_instr(1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 32'h0, 5'd5, 1,
               frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
    n_checks++;
    if (frz[0] !== 1'b0 || req[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nonmem_stall: freeze=%b req=%b required 0/0", frz[0], req[0]);
    end
    n_checks++;
    if (o_wb !== 1'b1 || o_dest !== 5'd5 || o_alu !== 32'h77) begin
      n_fail++; $display("[TB] FAIL nonmem_pass: wb=%b dest=%0d alu=%h required 1/5/77", o_wb, o_dest, o_alu);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] frz, req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    int pulses = 0;
    logic [31:0] data [2];
    data[0] = 32'h11112222;
    data[1] = 32'h33334444;
    for (int k = 0; k < 2; k++) begin
      exec_instr(1'b1, 1'b0, 1'b1, 32'h200 + 32'(k * 4), 32'h0, data[k], 5'd9, 1,
                 frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
      for (int i = 0; i < 16; i++)
        if (req[i] && (i == 0 || !req[i-1])) pulses++;
      n_checks++;
      if (o_rval !== data[k] || o_addr !== 32'h200 + 32'(k * 4)) begin
        n_fail++; $display("[TB] FAIL b2b_load%0d: rval=%h addr=%h required %h/%h",
                           k, o_rval, o_addr, data[k], 32'h200 + 32'(k * 4));
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("[TB] FAIL b2b_pulses: got %0d required 2", pulses);
    end
    WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b0 || freeze !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_idle: req=%b freeze=%b required 0/0", bus.mem_req, freeze);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] frz, req, exp_frz, exp_req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    logic [31:0] model_rval;
    do_reset();
    model_rval = 32'd0;
    for (int t = 0; t < 40; t++) begin
      int kind, n;
      logic r, w, wb;
      logic [31:0] addr, sv, rd;
      logic [4:0] dst;
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 6);
      r    = (kind == 1 || kind == 3);
      w    = (kind == 2 || kind == 3);
      wb   = 1'($urandom_range(0, 1));
      addr = $urandom; sv = $urandom; rd = $urandom;
      dst  = 5'($urandom_range(0, 31));
      exec_instr(r, w, wb, addr, sv, rd, dst, n,
                 frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
      if (r | w) begin
        exp_frz = (16'd1 << (n + 1)) - 16'd1;
        exp_req = ((16'd1 << n) - 16'd1) << 1;
        model_rval = r ? rd : 32'd0;
      end else begin
        exp_frz = 16'd0;
        exp_req = 16'd0;
      end
      n_checks++;
      if (frz !== exp_frz || req !== exp_req) begin
        n_fail++; $display("[TB] FAIL rnd%0d_occupancy: freeze=%b req=%b required %b/%b",
                           t, frz, req, exp_frz, exp_req);
      end
      n_checks++;
      if (o_wb !== wb || o_mr !== r || o_alu !== addr || o_dest !== dst) begin
        n_fail++; $display("[TB] FAIL rnd%0d_pass: wb=%b mr=%b alu=%h dest=%0d required %b/%b/%h/%0d",
                           t, o_wb, o_mr, o_alu, o_dest, wb, r, addr, dst);
      end
      n_checks++;
      if (o_rval !== model_rval) begin
        n_fail++; $display("[TB] FAIL rnd%0d_rval: got %h required %h", t, o_rval, model_rval);
      end
      if (r | w) begin
        n_checks++;
        if (o_addr !== addr || o_wdata !== sv || o_we !== (w & ~r) || o_stable !== 1'b1) begin
          n_fail++; $display("[TB] FAIL rnd%0d_bus: addr=%h wdata=%h we=%b stable=%b required %h/%h/%b/1",
                             t, o_addr, o_wdata, o_we, o_stable, addr, sv, w & ~r);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] frz, req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    int late_req = 0;
    do_reset();
    MEM_R_EN_IN = 1'b1; ALUResIn = 32'h300;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midwait_req: got %b required 1", bus.mem_req);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || memReadVal !== 32'd0 || bus.mem_addr !== 32'd0) begin
      n_fail++; $display("[TB] FAIL midwait_abort: req=%b rval=%h addr=%h required 0/0/0",
                         bus.mem_req, memReadVal, bus.mem_addr);
    end
    MEM_R_EN_IN = 1'b0;
    #1;
    n_checks++;
    if (freeze !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midwait_freeze: got %b required 0", freeze);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0 || memReadVal !== 32'd0) late_req++;
    end
    n_checks++;
    if (late_req != 0) begin
      n_fail++; $display("[TB] FAIL midwait_no_done: %0d cycles with activity required 0", late_req);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    exec_instr(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h5A5A5A5A, 5'd2, 3,
               frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
    n_checks++;
    if (frz !== 16'b01111 || o_rval !== 32'h5A5A5A5A) begin
      n_fail++; $display("[TB] FAIL midwait_recover: freeze=%b rval=%h required 01111/5a5a5a5a", frz, o_rval);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] frz, req;
    logic [31:0] o_addr, o_wdata, o_rval, o_alu;
    logic o_we, o_stable, o_wb, o_mr;
    logic [4:0] o_dest;
    do_reset();
    MEM_R_EN_IN = 1'b1; ALUResIn = 32'h400;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
    begin
      int waits = 0;
      logic done_seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (bus.mem_req) waits++;
        else begin
          done_seen = 1'b1;
          break;
        end
      end
      n_checks++;
      if (done_seen !== 1'b1 || waits != 255) begin
        n_fail++; $display("[TB] FAIL timeout_len: done=%b waits=%0d required 1/255", done_seen, waits);
      end
      n_checks++;
      if (memReadVal !== 32'hDEADBEEF || mem_err !== 1'b1 || freeze !== 1'b0) begin
        n_fail++; $display("[TB] FAIL timeout_result: rval=%h err=%b freeze=%b required deadbeef/1/0",
                           memReadVal, mem_err, freeze);
      end
      @(posedge clk); #1;
      exec_instr(1'b0, 1'b1, 1'b0, 32'h44, 32'h1, 32'h0, 5'd0, 1,
                 frz, req, o_addr, o_wdata, o_rval, o_we, o_stable, o_wb, o_mr, o_alu, o_dest);
      n_checks++;
      if (mem_err !== 1'b1 || o_rval !== 32'd0) begin
        n_fail++; $display("[TB] FAIL timeout_sticky: err=%b rval=%h required 1/0", mem_err, o_rval);
      end
      do_reset();
      n_checks++;
      if (mem_err !== 1'b0) begin
        n_fail++; $display("[TB] FAIL timeout_clear: err=%b required 0", mem_err);
      end
    end
`else
    for (int c = 0; c < 300; c++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b1 || freeze !== 1'b1 || mem_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL long_wait: req=%b freeze=%b err=%b required 1/1/0",
                         bus.mem_req, freeze, mem_err);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h600DCAFE;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (memReadVal !== 32'h600DCAFE || freeze !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL long_wait_done: rval=%h freeze=%b req=%b required 600dcafe/0/0",
                         memReadVal, freeze, bus.mem_req);
    end
    @(posedge clk); #1;
    MEM_R_EN_IN = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_nonmem();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Ports SHALL be as follows; clock is clk, reset is rst, one clock domain, reset asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  in  1 each  control bits from the EXE/MEM register.
REQ-005 ALUResIn  in  32  effective address / ALU result; stValIn  in  32  store data; destIn  in  5  destination register.
REQ-006 mem_req  out  1  memory request; mem_we  out  1  write strobe; mem_addr  out  32; mem_wdata  out  32.
REQ-007 mem_rdata  in  32  read data; mem_ready  in  1  memory completion.
REQ-008 freeze  out  1  stalls PC, IF/ID, ID/EXE and EXE/MEM registers when high.
REQ-009 WB_EN, MEM_R_EN  out  1; ALURes  out  32; memReadVal  out  32; dest  out  5; all feed the MEM/WB register.
REQ-010 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-011 FSM SHALL have states IDLE, WAIT, DONE; encoding is free.
REQ-012 IDLE: access = MEM_R_EN_IN | MEM_W_EN_IN; when access is 1, freeze SHALL be 1 combinationally in the same cycle and the next state SHALL be WAIT.
REQ-013 On IDLE->WAIT edge, mem_addr <= ALUResIn, mem_wdata <= stValIn, mem_we <= MEM_W_EN_IN & ~MEM_R_EN_IN.
REQ-014 MEM_R_EN_IN and MEM_W_EN_IN both high SHALL be treated as a read; write suppressed.
REQ-015 WAIT: mem_req = 1, freeze = 1; mem_addr, mem_wdata and mem_we stable until mem_ready.
REQ-016 WAIT with mem_ready = 1: next state DONE; on a read, memReadVal <= mem_rdata; on a write, memReadVal <= 0.
REQ-017 DONE: mem_req = 0, freeze = 0, lasts exactly one cycle, then IDLE unconditionally; access inputs in DONE SHALL be ignored (same instruction retiring).
REQ-018 mem_ready SHALL be ignored outside WAIT.
REQ-019 WB_EN, MEM_R_EN, ALURes and dest SHALL be combinational pass-through of WB_EN_IN, MEM_R_EN_IN, ALUResIn and destIn in all states.
REQ-020 Non-memory instruction (access = 0 in IDLE): freeze = 0, mem_req = 0, zero added latency.
REQ-021 Memory instruction latency: 1 (IDLE) + N (WAIT cycles until mem_ready) + 1 (DONE) cycles.
REQ-022 mem_ready in the first WAIT cycle SHALL give the minimum 3-cycle occupancy.

Reset
REQ-023 rst low SHALL immediately force IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, memReadVal = 0, mem_err = 0, timeout counter = 0.
REQ-024 Reset asserted mid-WAIT SHALL abandon the access; no DONE cycle is produced.
REQ-025 freeze after reset SHALL depend only on IDLE-state access decode.

Configuration
REQ-026 Macro MEM_TIMEOUT_EN SHALL compile in an 8-bit WAIT-cycle counter, cleared on entry to WAIT.
REQ-027 With MEM_TIMEOUT_EN: after 255 WAIT cycles without mem_ready, next state DONE, memReadVal <= 32'hDEADBEEF, mem_err <= 1 (sticky until reset).
REQ-028 Without MEM_TIMEOUT_EN: WAIT SHALL persist indefinitely; mem_err tied 0; no counter logic.

Verification
REQ-029 Load, ALUResIn=0x100, mem_ready in 2nd WAIT cycle with mem_rdata=0xCAFEF00D -> freeze high 3 cycles, mem_addr=0x100, memReadVal=0xCAFEF00D in DONE.
REQ-030 Store, ALUResIn=0x40, stValIn=0x12345678, immediate mem_ready -> mem_we=1, mem_wdata=0x12345678, freeze high 2 cycles, memReadVal=0.
REQ-031 Back-to-back loads -> DONE then IDLE re-accepts the second load; exactly two mem_req pulses, no double-issue in DONE.
REQ-032 Non-memory op, WB_EN_IN=1, destIn=5 -> freeze=0, mem_req=0, WB_EN=1, dest=5 same cycle.
REQ-033 rst low in WAIT -> mem_req=0 same cycle, state IDLE, memReadVal=0.
REQ-034 MEM_TIMEOUT_EN defined, mem_ready held 0 -> DONE after 255 WAIT cycles, memReadVal=0xDEADBEEF, mem_err=1 until reset.
